pio_out_blink: RTL

PIO_OUT_BLINK -- requirements
Module: pio_out_blink

---
 rtl/pio_out_blink.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM output PIO with SET/CLEAR and per-bit blink.
// Blink logic (BLINK_MASK, PERIOD, prescaler) is built only with PIO_OUT_BLINK_EN.
module pio_out_blink #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
    parameter int               PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             blink_phase
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
`ifdef PIO_OUT_BLINK_EN
    localparam logic [2:0] ADDR_MASK   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;
`endif

    logic             write;
    logic             wr_data;
    logic             wr_set;
    logic             wr_clear;
    logic [WIDTH-1:0] wd_port;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] blink_bits;

`ifdef PIO_OUT_BLINK_EN
    logic                  wr_mask;
    logic                  wr_period;
    logic [WIDTH-1:0]      mask;
    logic [PRESCALE_W-1:0] period;
    logic [PRESCALE_W-1:0] cnt;
    logic                  phase;
    logic                  period_zero;
    logic                  wrap;
`endif

    assign write   = chipselect & ~write_n;
    assign wd_port = writedata[WIDTH-1:0];

    // Decode the write strobe into one enable per register.
    always_comb begin
        wr_data   = 1'b0;
        wr_set    = 1'b0;
        wr_clear  = 1'b0;
`ifdef PIO_OUT_BLINK_EN
        wr_mask   = 1'b0;
        wr_period = 1'b0;
`endif
        if (write) begin
            unique case (address)
                ADDR_DATA:   wr_data   = 1'b1;
                ADDR_SET:    wr_set    = 1'b1;
                ADDR_CLEAR:  wr_clear  = 1'b1;
`ifdef PIO_OUT_BLINK_EN
                ADDR_MASK:   wr_mask   = 1'b1;
                ADDR_PERIOD: wr_period = 1'b1;
`endif
                default:     wr_data   = 1'b0;
            endcase
        end
    end

    // Next DATA value: direct write, bit-set or bit-clear.
    always_comb begin
        data_nxt = data;
        if (wr_data) begin
            data_nxt = wd_port;
        end else if (wr_set) begin
            data_nxt = data | wd_port;
        end else if (wr_clear) begin
            data_nxt = data & ~wd_port;
        end
    end

    // DATA register; reset wins over any coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= RESET_VALUE;
        end else begin
            data <= data_nxt;
        end
    end

`ifdef PIO_OUT_BLINK_EN

    assign period_zero = (period == '0);
    assign wrap        = !period_zero &&
                         (cnt == period - PRESCALE_W'(1));

    // BLINK_MASK register; writing it leaves the prescaler alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= wd_port;
        end
    end

    // PERIOD register.
    always_ff @(posedge clk) begin
        if (reset) begin
            period <= '0;
        end else if (wr_period) begin
            period <= writedata[PRESCALE_W-1:0];
        end
    end

    // Prescaler: wraps at PERIOD-1 and flips the phase on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wr_period || period_zero) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + PRESCALE_W'(1);
        end
    end

    assign blink_bits  = mask & {WIDTH{phase}};
    assign blink_phase = phase;

`else

    assign blink_bits  = '0;
    assign blink_phase = 1'b0;

`endif

    assign out_port = data ^ blink_bits;

    // Zero-wait-state read mux; write-only and reserved words read as 0.
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA:   readdata = 32'(data);
`ifdef PIO_OUT_BLINK_EN
            ADDR_MASK:   readdata = 32'(mask);
            ADDR_PERIOD: readdata = 32'(period);
`endif
            default:     readdata = '0;
        endcase
    end

endmodule
